// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FIFO read-FSM states,
// uart_tx state encodings and the default data width.
package uart_pkg;

   localparam int UART_WIDTH = 8;

   typedef enum logic [1:0] {
      S_ARM   = 2'd0,
      S_OFFER = 2'd1,
      S_DRAIN = 2'd2
   } fifo_rd_state_e;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } uart_tx_state_e;

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH register array: one synchronous write port and an
// asynchronous read port. Contents are not reset.
module fifo_ram #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) mem_q[i_waddr] <= i_wdata;
   end

   assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO feeding uart_tx through its i_data/i_ready/o_next
// handshake; offers one byte per transmitter frame.
//
//   state   | meaning
//   S_ARM   | waiting for the transmitter to be idle (i_next) with data stored
//   S_OFFER | o_ready high, head byte held on o_data until i_next drops
//   S_DRAIN | byte taken; wait for i_next to return before arming again
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = UART_WIDTH,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic             i_divided_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_wr,
   input  logic [WIDTH-1:0] i_wdata,
   output logic             o_full,
   output logic             o_empty,
   output logic [CW-1:0]    o_count,
   output logic             o_overflow,
   input  logic             i_next,
   output logic [WIDTH-1:0] o_data,
   output logic             o_ready
);

   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   fifo_rd_state_e state_q, state_d;
   logic [AW-1:0]  wptr_q, wptr_d;
   logic [AW-1:0]  rptr_q, rptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic           ready_q, ready_d;
   logic           overflow_q, overflow_d;
   logic           full_q, full_d;
   logic           empty_q, empty_d;
   logic           wr_ok;
   logic           pop;

   fifo_ram #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_ram (
      .i_clk   (i_divided_clk),
      .i_we    (wr_ok),
      .i_waddr (wptr_q),
      .i_wdata (i_wdata),
      .i_raddr (rptr_q),
      .o_rdata (o_data)
   );

   // Illegal encodings recover even while i_en is low.
   always_comb begin
      state_d = state_q;
      ready_d = ready_q;
      pop     = 1'b0;
      case (state_q)
         S_ARM: begin
            if (i_en) begin
               ready_d = 1'b0;
               if (i_next && (count_q != '0)) begin
                  state_d = S_OFFER;
                  ready_d = 1'b1;
               end
            end
         end
         S_OFFER: begin
            if (i_en) begin
               ready_d = 1'b1;
               if (!i_next) begin
                  pop     = 1'b1;
                  ready_d = 1'b0;
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (i_en) begin
               ready_d = 1'b0;
               if (i_next) state_d = S_ARM;
            end
         end
         default: begin
            state_d = S_ARM;
            ready_d = 1'b0;
         end
      endcase
   end

   // Fullness is judged on the pre-edge count, so a same-cycle pop never
   // makes room for a write.
   always_comb begin
      wr_ok      = i_wr && (count_q != FULL_CNT);
      wptr_d     = wr_ok ? wptr_q + 1'b1 : wptr_q;
      rptr_d     = pop ? rptr_q + 1'b1 : rptr_q;
      count_d    = count_q;
      if (wr_ok && !pop)      count_d = count_q + 1'b1;
      else if (!wr_ok && pop) count_d = count_q - 1'b1;
      overflow_d = overflow_q | (i_wr & ~wr_ok);
      full_d     = (count_d == FULL_CNT);
      empty_d    = (count_d == '0);
   end

   always_ff @(posedge i_divided_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= S_ARM;
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         ready_q    <= 1'b0;
         overflow_q <= 1'b0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         ready_q    <= ready_d;
         overflow_q <= overflow_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
      end
   end

   assign o_ready    = ready_q;
   assign o_count    = count_q;
   assign o_full     = full_q;
   assign o_empty    = empty_q;
   assign o_overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo with a behavioural uart_tx consumer and
// a queue-based reference model of the FIFO contents.
module tb_uart_tx_fifo;

   localparam int DEPTH = 16;
   localparam int WIDTH = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       wr;
   logic [7:0] wdata;
   logic       full, empty, ovf, ready;
   logic [4:0] count;
   logic [7:0] o_data;
   logic       tx_next;

   always #5 clk = ~clk;

   uart_tx_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) dut (
      .i_divided_clk (clk),
      .i_rst         (rst),
      .i_en          (en),
      .i_wr          (wr),
      .i_wdata       (wdata),
      .o_full        (full),
      .o_empty       (empty),
      .o_count       (count),
      .o_overflow    (ovf),
      .i_next        (tx_next),
      .o_data        (o_data),
      .o_ready       (ready)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transmitter model: idle with o_next high, takes a byte after holding
   // for tx_hold edges of o_ready, then stays busy for a random frame.
   int         tx_busy      = 0;
   int         tx_hold_cnt  = 0;
   int         tx_hold_r    = 0;
   int         tx_hold_fix  = 0;
   bit         tx_hold_rand = 0;
   bit         tx_stall     = 0;
   int         tx_latch_cnt = 0;
   logic [7:0] tx_data_q;
   int         tx_hold_lim;

   // Reference model: contents as a queue, plus expected transmitted bytes.
   logic [7:0] m_q[$];
   int         exp_tx[$];
   bit         m_pop_due = 0;
   bit         m_ovf     = 0;
   int         pre;

   assign tx_hold_lim = tx_hold_rand ? tx_hold_r : tx_hold_fix;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_next     <= 1'b1;
         tx_busy     <= 0;
         tx_hold_cnt <= 0;
         m_q.delete();
         exp_tx.delete();
         m_pop_due = 0;
         m_ovf     = 0;
      end else begin
         pre = m_q.size();
         if (en && m_pop_due) begin
            if (m_q.size() > 0) m_q.delete(0);
            m_pop_due = 0;
         end
         if (en) begin
            if (tx_busy > 0) begin
               if (tx_busy == 1) tx_next <= 1'b1;
               tx_busy <= tx_busy - 1;
            end else if (tx_stall) begin
               tx_next <= 1'b0;
            end else if (!tx_next) begin
               tx_next <= 1'b1;
            end else if (ready) begin
               if (tx_hold_cnt < tx_hold_lim) begin
                  tx_hold_cnt <= tx_hold_cnt + 1;
               end else begin
                  tx_data_q    <= o_data;
                  tx_next      <= 1'b0;
                  tx_busy      <= int'($urandom_range(2, 6));
                  tx_hold_cnt  <= 0;
                  tx_hold_r    <= int'($urandom_range(0, 4));
                  tx_latch_cnt <= tx_latch_cnt + 1;
                  exp_tx.push_back(m_q.size() > 0 ? int'(m_q[0]) : -1);
                  m_pop_due = 1;
               end
            end
         end
         if (wr) begin
            if (pre < DEPTH) m_q.push_back(wdata);
            else             m_ovf = 1;
         end
      end
   end

   // Monitor: compares DUT status and transmitted bytes on the falling edge.
   int         seen = 0;
   logic       prev_ready = 1'b0;
   logic [7:0] held;

   always @(negedge clk) begin
      if (rst) begin
         seen       = tx_latch_cnt;
         prev_ready = 1'b0;
      end else begin
         chk("count",    32'(count), 32'(m_q.size()));
         chk("full",     32'(full),  32'(m_q.size() == DEPTH));
         chk("empty",    32'(empty), 32'(m_q.size() == 0));
         chk("overflow", 32'(ovf),   32'(m_ovf));
         if (ready && prev_ready) chk("data_stable", 32'(o_data), 32'(held));
         if (ready) held = o_data;
         prev_ready = ready;
         if (seen != tx_latch_cnt) begin
            seen++;
            if (exp_tx.size() == 0) chk("tx_unexpected", 32'd1, 32'd0);
            else                    chk("tx_byte", 32'(tx_data_q), 32'(exp_tx.pop_front()));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_byte(input logic [7:0] b);
      wr    = 1'b1;
      wdata = b;
      tick();
      wr    = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic wait_latch(input int target, input string name);
      int k;
      for (k = 0; k < 200 && tx_latch_cnt < target; k++) tick();
      if (tx_latch_cnt < target) chk({name, "_timeout"}, 32'd1, 32'd0);
   endtask

   task automatic drain(input string name);
      bit done = 0;
      for (int k = 0; k < 3000 && !done; k++) begin
         if (m_q.size() == 0 && exp_tx.size() == 0 && !ready && tx_busy == 0 && tx_next && !m_pop_due)
            done = 1;
         else
            tick();
      end
      chk({name, "_drained"}, 32'(done), 32'd1);
   endtask

   int start;
   int rdy_cycles;

   initial begin
      rst = 1'b1; en = 1'b1; wr = 1'b0; wdata = 8'h00;
      do_reset();

      // reset state
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full",  32'(full),  32'd0);
      chk("rst_ovf",   32'(ovf),   32'd0);

      // single byte, one offer, no re-offer while busy
      start = tx_latch_cnt;
      wr_byte(8'h55);
      chk("ready_before", 32'(ready), 32'd0);
      tick();
      chk("ready_latency", 32'(ready), 32'd1);
      wait_latch(start + 1, "single");
      chk("single_byte", 32'(tx_data_q), 32'h55);
      tick();
      chk("single_empty", 32'(empty), 32'd1);
      for (int k = 0; k < 20 && tx_busy != 0; k++) begin
         chk("no_reoffer", 32'(ready), 32'd0);
         tick();
      end
      drain("single");

      // fill to full, overflow, ordered drain
      tx_stall = 1;
      do_reset();
      for (int i = 1; i <= DEPTH; i++) wr_byte(8'(i));
      chk("fill_full",  32'(full),  32'd1);
      chk("fill_count", 32'(count), 32'd16);
      wr_byte(8'hAA);
      chk("ovf_set",   32'(ovf),   32'd1);
      chk("ovf_count", 32'(count), 32'd16);
      start = tx_latch_cnt;
      tx_stall = 0;
      drain("fill");
      chk("fill_tx_n", 32'(tx_latch_cnt - start), 32'd16);

      // write while full on the pop edge
      tx_stall = 1;
      do_reset();
      for (int i = 0; i < DEPTH; i++) wr_byte(8'($urandom_range(0, 255)));
      start = tx_latch_cnt;
      tx_stall = 0;
      wait_latch(start + 1, "fullpop");
      wr = 1'b1; wdata = 8'hEE;
      tick();
      wr = 1'b0;
      chk("fullpop_count", 32'(count), 32'd15);
      chk("fullpop_ovf",   32'(ovf),   32'd1);
      drain("fullpop");

      // transmitter holds o_next for 5 cycles after o_ready
      do_reset();
      tx_hold_fix = 5;
      start = tx_latch_cnt;
      rdy_cycles = 0;
      wr_byte(8'h77);
      for (int k = 0; k < 50 && tx_latch_cnt == start; k++) begin
         if (ready) rdy_cycles++;
         tick();
      end
      chk("hold_ready_cycles", 32'(rdy_cycles >= 5), 32'd1);
      chk("hold_byte", 32'(tx_data_q), 32'h77);
      drain("hold");
      chk("hold_one_pop", 32'(tx_latch_cnt - start), 32'd1);
      tx_hold_fix = 0;

      // enable low freezes reading, writes still land
      do_reset();
      en = 1'b0;
      start = tx_latch_cnt;
      wr_byte(8'hA1); wr_byte(8'hA2); wr_byte(8'hA3);
      repeat (5) tick();
      chk("en_ready", 32'(ready), 32'd0);
      chk("en_count", 32'(count), 32'd3);
      wr_byte(8'hA4);
      chk("en_count4", 32'(count), 32'd4);
      en = 1'b1;
      drain("en");
      chk("en_tx_n", 32'(tx_latch_cnt - start), 32'd4);

      // reset while offering
      tx_hold_fix = 8;
      wr_byte(8'h11);
      wr_byte(8'h22);
      for (int k = 0; k < 20 && !ready; k++) tick();
      chk("rst_mid_offering", 32'(ready), 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_mid_ready", 32'(ready), 32'd0);
      chk("rst_mid_count", 32'(count), 32'd0);
      tick();
      rst = 1'b0;
      tx_hold_fix = 0;
      tick();
      start = tx_latch_cnt;
      wr_byte(8'h3C);
      wait_latch(start + 1, "rst_mid");
      chk("rst_mid_next", 32'(tx_data_q), 32'h3C);
      drain("rst_mid");

      // randomized traffic with enable gaps and bursts
      tx_hold_rand = 1;
      for (int c = 0; c < 3000; c++) begin
         en    = ($urandom_range(0, 9) != 0);
         wr    = ($urandom_range(0, 99) < ((c / 500) % 2 == 0 ? 30 : 70));
         wdata = 8'($urandom_range(0, 255));
         tick();
      end
      wr = 1'b0;
      en = 1'b1;
      drain("random");
      tx_hold_rand = 0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
